vgs_pulse_scheduler: RTL and testbench

VGS_PULSE_SCHEDULER -- requirements
Module: vgs_pulse_scheduler

---
 rtl/vgs_pulse_scheduler.sv | 167 ++++++++++++++++
 tb/tb_vgs_pulse_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vgs_pulse_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vgs_pulse_scheduler : periodic gate-drive request generator with abort and fault latch.
// Optional soft-start ramp via macro VGS_SOFT_START_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module vgs_pulse_scheduler #(
  parameter int CW      = 16,
  parameter int MIN_OFF = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] on_time,
  input  logic          fault,
  input  logic          fault_clr,
  output logic          vgs_req,
  output logic          busy,
  output logic          fault_latched,
  output logic [15:0]   pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [CW-1:0] MIN_OFF_C  = CW'(MIN_OFF);
  localparam logic [CW-1:0] ZERO_PER_C = CW'(MIN_OFF + 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0] per_q, per_nx, eff_q, eff_nx;
  logic [CW-1:0] start_per, start_eff, on_lim;
  logic          aborting, aborting_nx;
  logic          flt_nx, vgs_nx, do_start;
  logic [15:0]   pcnt_nx;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

`ifdef VGS_SOFT_START_EN
  logic [CW-1:0] ramp, ramp_use;
  // The ramp restarts at 1 from IDLE and grows by one per completed period.
  assign ramp_use = (state == IDLE) ? CW'(1) :
                    ((ramp == CNT_MAX) ? ramp : ramp + CW'(1));
`endif

  // Period and effective on-time for a period starting on the next edge.
  always_comb begin
    start_per = (period == '0) ? ZERO_PER_C : period;
    on_lim    = period - MIN_OFF_C;
    if (period <= MIN_OFF_C) begin
      start_eff = '0;
    end else begin
      start_eff = (on_time < on_lim) ? on_time : on_lim;
`ifdef VGS_SOFT_START_EN
      if (ramp_use < start_eff) start_eff = ramp_use;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    per_nx      = per_q;
    eff_nx      = eff_q;
    aborting_nx = aborting;
    flt_nx      = fault_latched;
    pcnt_nx     = pulse_cnt;
    do_start    = 1'b0;
    if (fault) begin
      state_nx    = FAULT;
      flt_nx      = 1'b1;
      cnt_nx      = '0;
      aborting_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !fault_latched) do_start = 1'b1;
        end
        ON: begin
          if (!enable) begin
            state_nx    = OFF;
            aborting_nx = 1'b1;
            cnt_nx      = CW'(1);
          end else if (cnt >= eff_q) begin
            state_nx = OFF;
            pcnt_nx  = pulse_cnt + 16'd1;
            cnt_nx   = cnt_inc;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        OFF: begin
          if (aborting) begin
            if (cnt >= MIN_OFF_C) begin
              state_nx    = IDLE;
              aborting_nx = 1'b0;
              cnt_nx      = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else if (cnt >= per_q) begin
            if (enable) begin
              do_start = 1'b1;
            end else begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state_nx = IDLE;
            flt_nx   = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    if (do_start) begin
      per_nx   = start_per;
      eff_nx   = start_eff;
      cnt_nx   = CW'(1);
      state_nx = (start_eff != '0) ? ON : OFF;
    end
    vgs_nx = (state_nx == ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      per_q         <= '0;
      eff_q         <= '0;
      aborting      <= 1'b0;
      vgs_req       <= 1'b0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
      pulse_cnt     <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      per_q         <= per_nx;
      eff_q         <= eff_nx;
      aborting      <= aborting_nx;
      vgs_req       <= vgs_nx;
      busy          <= (state_nx != IDLE);
      fault_latched <= flt_nx;
      pulse_cnt     <= pcnt_nx;
    end
  end

`ifdef VGS_SOFT_START_EN
  always_ff @(posedge clk) begin
    if (rst)           ramp <= '0;
    else if (do_start) ramp <= ramp_use;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vgs_pulse_scheduler.sv
`default_nettype none
// Directed self-checking bench for vgs_pulse_scheduler (CW=16, MIN_OFF=4).
module tb_vgs_pulse_scheduler;
  localparam int CW      = 16;
  localparam int MIN_OFF = 4;

  logic          clk = 1'b0;
  logic          rst, enable, fault, fault_clr;
  logic [CW-1:0] period, on_time;
  logic          vgs_req, busy, fault_latched;
  logic [15:0]   pulse_cnt;

  int   total = 0;
  int   bad   = 0;
  logic hist [0:63];

  vgs_pulse_scheduler #(.CW(CW), .MIN_OFF(MIN_OFF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .on_time(on_time),
    .fault(fault), .fault_clr(fault_clr), .vgs_req(vgs_req), .busy(busy),
    .fault_latched(fault_latched), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hist[i] = vgs_req;
    end
  endtask

  // Expected high width of period k for a capped on-time eff.
  function automatic int exp_w(input int k, input int eff);
`ifdef VGS_SOFT_START_EN
    return (k + 1 < eff) ? k + 1 : eff;
`else
    return (k >= 0) ? eff : 0;
`endif
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    period = '0; on_time = '0;
    tick(); tick();
    check("rst_vgs", vgs_req, 0);
    check("rst_busy", busy, 0);
    check("rst_flt", fault_latched, 0);
    check("rst_pcnt", pulse_cnt, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // 10-cycle period, 3 high
    period = 10; on_time = 3; enable = 1'b1;
    capture(30);
    for (int i = 0; i < 30; i++)
      check("pat_10_3", hist[i], ((i % 10) < exp_w(i / 10, 3)) ? 1 : 0);
    check("pcnt_after30", pulse_cnt, 3);
    check("run_busy", busy, 1);
    enable = 1'b0;
    tick();
    check("stop_busy", busy, 0);
    check("stop_vgs", vgs_req, 0);

    // on_time capped to period - MIN_OFF
    period = 10; on_time = 9; enable = 1'b1;
    capture(20);
    for (int i = 0; i < 20; i++)
      check("pat_10_9", hist[i], ((i % 10) < exp_w(i / 10, 6)) ? 1 : 0);
    enable = 1'b0;
    tick();
    check("cap_idle", busy, 0);
    check("cap_pcnt", pulse_cnt, 5);

    // period <= MIN_OFF: no pulse, still busy
    period = 3; on_time = 2; enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("p3_vgs", vgs_req, 0);
      check("p3_busy", busy, 1);
    end
    enable = 1'b0;
    tick();
    check("p3_idle", busy, 0);

    // period = 0 behaves as MIN_OFF+1 with no pulse
    period = 0; on_time = 3; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("p0_vgs", vgs_req, 0);
      check("p0_busy", busy, 1);
    end
    enable = 1'b0;
    tick();
    check("p0_idle", busy, 0);
    check("p0_pcnt", pulse_cnt, 5);

    // abort on the 2nd ON cycle of a 5-cycle pulse
    period = 20; on_time = 5; enable = 1'b1;
    tick();
    check("ab_on1", vgs_req, 1);
    tick();
    check("ab_on2", vgs_req, 1);
    enable = 1'b0;
    for (int i = 0; i < MIN_OFF; i++) begin
      tick();
      check("ab_off_vgs", vgs_req, 0);
      check("ab_off_busy", busy, 1);
    end
    tick();
    check("ab_idle", busy, 0);
    check("ab_pcnt", pulse_cnt, 5);

    // fault mid-ON, clear blocked while fault is still high
    period = 10; on_time = 5; enable = 1'b1;
    tick(); tick();
    check("f_on", vgs_req, 1);
    fault = 1'b1;
    tick();
    check("f_vgs", vgs_req, 0);
    check("f_latched", fault_latched, 1);
    fault_clr = 1'b1;
    tick();
    check("f_both_latched", fault_latched, 1);
    check("f_both_busy", busy, 1);
    fault = 1'b0; enable = 1'b0;
    tick();
    check("f_clr_latched", fault_latched, 0);
    check("f_clr_busy", busy, 0);
    fault_clr = 1'b0;
    check("f_pcnt", pulse_cnt, 5);

    // reset mid-ON, then reset priority over fault
    period = 10; on_time = 5; enable = 1'b1;
    tick(); tick();
    check("r_on", vgs_req, 1);
    rst = 1'b1;
    tick();
    check("r_vgs", vgs_req, 0);
    check("r_busy", busy, 0);
    check("r_flt", fault_latched, 0);
    check("r_pcnt", pulse_cnt, 0);
    fault = 1'b1;
    tick();
    check("r_fault_blocked", fault_latched, 0);
    rst = 1'b0; enable = 1'b0;
    tick();
    check("r_fault_relatch", fault_latched, 1);
    fault = 1'b0; fault_clr = 1'b1;
    tick();
    check("r_fault_clr", fault_latched, 0);
    fault_clr = 1'b0;

    // per-period high widths (ramped when soft-start is built in)
    period = 10; on_time = 3; enable = 1'b1;
    capture(40);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      for (int j = 0; j < 10; j++) w += hist[k * 10 + j] ? 1 : 0;
`ifdef VGS_SOFT_START_EN
      check("ss_width", w, (k == 0) ? 1 : (k == 1) ? 2 : 3);
`else
      check("ss_width", w, 3);
`endif
    end
    check("ss_pcnt", pulse_cnt, 4);
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
